fwd_hazard_ctrl: RTL and testbench



---
 rtl/fwd_hazard_ctrl_pkg.sv | 18 +
 rtl/fwd_hazard_ctrl_fwd_select.sv | 29 ++
 rtl/fwd_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / hazard control block.
// Forward-select encodings, FSM state enum and default widths.
package fwd_hazard_ctrl_pkg;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 32;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LU_STALL = 2'b01,
      ST_FREEZE   = 2'b10
   } ctrl_state_e;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select.sv
// Forward-select compare for one ID-stage source register.
// The EX producer wins over MEM because it holds the newest value.
module fwd_select
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] src_i,
   input  logic          ex_regwrite_i,
   input  logic [AW-1:0] ex_rd_i,
   input  logic          mem_regwrite_i,
   input  logic [AW-1:0] mem_rd_i,
   output logic [1:0]    sel_o
);

   logic src_nz;
   assign src_nz = (src_i != '0);

   // Priority compare: EX producer, then MEM producer, else register file.
   always_comb begin
      sel_o = FWD_RF;
      if (ex_regwrite_i && (ex_rd_i == src_i) && src_nz) begin
         sel_o = FWD_MEM;
      end else if (mem_regwrite_i && (mem_rd_i == src_i) && src_nz) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Pipeline control: EX forwarding selects, load-use stall,
// memory-wait freeze, branch flush and performance counters.
module fwd_hazard_ctrl #(
   parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
   parameter int CNT_W  = fwd_hazard_ctrl_pkg::CNT_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              ex_regwrite_i,
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              mem_regwrite_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic              branch_taken_i,
   input  logic              mem_busy_i,
   output logic [1:0]        forward_a_o,
   output logic [1:0]        forward_b_o,
   output logic              pc_write_o,
   output logic              if_id_write_o,
   output logic              if_id_flush_o,
   output logic              id_ex_bubble_o,
   output logic              pipe_freeze_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   import fwd_hazard_ctrl_pkg::*;

   ctrl_state_e      state_q, state_d;
   logic [1:0]       fwd_a_q, fwd_a_d;
   logic [1:0]       fwd_b_q, fwd_b_d;
   logic [1:0]       sel_a, sel_b;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             lu;

   fwd_select #(.AW(REG_AW)) u_sel_rs (
      .src_i          (id_rs_i),
      .ex_regwrite_i  (ex_regwrite_i),
      .ex_rd_i        (ex_rd_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_rd_i       (mem_rd_i),
      .sel_o          (sel_a)
   );

   fwd_select #(.AW(REG_AW)) u_sel_rt (
      .src_i          (id_rt_i),
      .ex_regwrite_i  (ex_regwrite_i),
      .ex_rd_i        (ex_rd_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_rd_i       (mem_rd_i),
      .sel_o          (sel_b)
   );

   assign lu = ex_memread_i && (ex_rd_i != '0) &&
               ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

   // Next state; freeze dominates, load-use only matters from RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (mem_busy_i)  state_d = ST_FREEZE;
            else if (lu)     state_d = ST_LU_STALL;
         end
         ST_LU_STALL: begin
            state_d = mem_busy_i ? ST_FREEZE : ST_RUN;
         end
         ST_FREEZE: begin
            state_d = mem_busy_i ? ST_FREEZE : ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Pipeline enables with priority freeze > load-use > branch.
   always_comb begin
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      pipe_freeze_o  = 1'b0;
      if (mem_busy_i) begin
         pipe_freeze_o = 1'b1;
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
      end else if (lu) begin
         pc_write_o     = 1'b0;
         if_id_write_o  = 1'b0;
         id_ex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         if_id_flush_o = 1'b1;
      end
   end

   // Forward selects and counters: hold on freeze, clear on bubble.
   always_comb begin
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
      stall_d = stall_q;
      flush_d = flush_q;
      if (mem_busy_i) begin
         fwd_a_d = fwd_a_q;
         fwd_b_d = fwd_b_q;
      end else if (id_ex_bubble_o) begin
         fwd_a_d = FWD_RF;
         fwd_b_d = FWD_RF;
      end
      if (id_ex_bubble_o) stall_d = stall_q + 1'b1;
      if (if_id_flush_o)  flush_d = flush_q + 1'b1;
   end

   // State, select and counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign forward_a_o = fwd_a_q;
   assign forward_b_o = fwd_b_q;
   assign stall_cnt_o = stall_q;
   assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl.
// Each task drives one scenario and checks hand-computed values.
module tb_fwd_hazard_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  id_rs_i, id_rt_i, ex_rd_i, mem_rd_i;
   logic        ex_regwrite_i, ex_memread_i, mem_regwrite_i;
   logic        branch_taken_i, mem_busy_i;
   logic [1:0]  forward_a_o, forward_b_o;
   logic        pc_write_o, if_id_write_o, if_id_flush_o;
   logic        id_ex_bubble_o, pipe_freeze_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .id_rs_i        (id_rs_i),
      .id_rt_i        (id_rt_i),
      .ex_regwrite_i  (ex_regwrite_i),
      .ex_memread_i   (ex_memread_i),
      .ex_rd_i        (ex_rd_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_rd_i       (mem_rd_i),
      .branch_taken_i (branch_taken_i),
      .mem_busy_i     (mem_busy_i),
      .forward_a_o    (forward_a_o),
      .forward_b_o    (forward_b_o),
      .pc_write_o     (pc_write_o),
      .if_id_write_o  (if_id_write_o),
      .if_id_flush_o  (if_id_flush_o),
      .id_ex_bubble_o (id_ex_bubble_o),
      .pipe_freeze_o  (pipe_freeze_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   task automatic clear_inputs();
      id_rs_i = 0; id_rt_i = 0; ex_rd_i = 0; mem_rd_i = 0;
      ex_regwrite_i = 0; ex_memread_i = 0; mem_regwrite_i = 0;
      branch_taken_i = 0; mem_busy_i = 0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      clear_inputs();
      tick();
      tick();
      checks++;
      if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00) begin
         failures++;
         $display("FAIL reset_fwd got=%b/%b exp=00/00", forward_a_o, forward_b_o);
      end
      checks++;
      if (stall_cnt_o !== 0 || flush_cnt_o !== 0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
      end
      checks++;
      if (pc_write_o !== 1'b1 || pipe_freeze_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl pc=%b frz=%b exp=1/0", pc_write_o, pipe_freeze_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_forward_priority();
      clear_inputs();
      ex_regwrite_i = 1; ex_rd_i = 8; id_rs_i = 8;
      mem_regwrite_i = 1; mem_rd_i = 8; id_rt_i = 9;
      tick();
      checks++;
      if (forward_a_o !== 2'b10 || forward_b_o !== 2'b00) begin
         failures++;
         $display("FAIL fwd_ex_prio got=%b/%b exp=10/00", forward_a_o, forward_b_o);
      end
      ex_rd_i = 0; mem_rd_i = 0; id_rs_i = 0; id_rt_i = 0;
      tick();
      checks++;
      if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00) begin
         failures++;
         $display("FAIL fwd_r0 got=%b/%b exp=00/00", forward_a_o, forward_b_o);
      end
      ex_rd_i = 3; mem_rd_i = 9; id_rs_i = 8; id_rt_i = 9;
      tick();
      checks++;
      if (forward_a_o !== 2'b00 || forward_b_o !== 2'b01) begin
         failures++;
         $display("FAIL fwd_mem got=%b/%b exp=00/01", forward_a_o, forward_b_o);
      end
   endtask

   task automatic test_load_use();
      clear_inputs();
      ex_memread_i = 1; ex_regwrite_i = 1; ex_rd_i = 5;
      id_rs_i = 1; id_rt_i = 5;
      #1;
      checks++;
      if (pc_write_o !== 0 || if_id_write_o !== 0 || id_ex_bubble_o !== 1) begin
         failures++;
         $display("FAIL lu_detect pc=%b ifid=%b bub=%b exp=0/0/1",
                  pc_write_o, if_id_write_o, id_ex_bubble_o);
      end
      tick();
      checks++;
      if (stall_cnt_o !== 1 || forward_b_o !== 2'b00) begin
         failures++;
         $display("FAIL lu_count stall=%0d fb=%b exp=1/00", stall_cnt_o, forward_b_o);
      end
      ex_memread_i = 0; ex_regwrite_i = 0; ex_rd_i = 0;
      mem_regwrite_i = 1; mem_rd_i = 5;
      #1;
      checks++;
      if (pc_write_o !== 1 || if_id_write_o !== 1 || id_ex_bubble_o !== 0) begin
         failures++;
         $display("FAIL lu_release pc=%b ifid=%b bub=%b exp=1/1/0",
                  pc_write_o, if_id_write_o, id_ex_bubble_o);
      end
      tick();
      checks++;
      if (forward_b_o !== 2'b01 || stall_cnt_o !== 1) begin
         failures++;
         $display("FAIL lu_fwd_wb fb=%b stall=%0d exp=01/1", forward_b_o, stall_cnt_o);
      end
   endtask

   task automatic test_branch();
      clear_inputs();
      ex_memread_i = 1; ex_regwrite_i = 1; ex_rd_i = 5; id_rt_i = 5;
      branch_taken_i = 1;
      #1;
      checks++;
      if (if_id_flush_o !== 0 || id_ex_bubble_o !== 1) begin
         failures++;
         $display("FAIL br_lu flush=%b bub=%b exp=0/1", if_id_flush_o, id_ex_bubble_o);
      end
      tick();
      checks++;
      if (flush_cnt_o !== 0 || stall_cnt_o !== 2) begin
         failures++;
         $display("FAIL br_lu_cnt flush=%0d stall=%0d exp=0/2", flush_cnt_o, stall_cnt_o);
      end
      ex_memread_i = 0; ex_regwrite_i = 0; ex_rd_i = 0;
      #1;
      checks++;
      if (if_id_flush_o !== 1 || pc_write_o !== 1 || if_id_write_o !== 1) begin
         failures++;
         $display("FAIL br_flush flush=%b pc=%b ifid=%b exp=1/1/1",
                  if_id_flush_o, pc_write_o, if_id_write_o);
      end
      tick();
      checks++;
      if (flush_cnt_o !== 1) begin
         failures++;
         $display("FAIL br_cnt got=%0d exp=1", flush_cnt_o);
      end
   endtask

   task automatic test_freeze();
      clear_inputs();
      ex_regwrite_i = 1; ex_rd_i = 7; id_rs_i = 7;
      tick();
      checks++;
      if (forward_a_o !== 2'b10) begin
         failures++;
         $display("FAIL frz_setup fa=%b exp=10", forward_a_o);
      end
      mem_busy_i = 1; branch_taken_i = 1;
      ex_memread_i = 1; ex_rd_i = 6; id_rs_i = 0; id_rt_i = 6;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (pipe_freeze_o !== 1 || pc_write_o !== 0 ||
             if_id_flush_o !== 0 || id_ex_bubble_o !== 0) begin
            failures++;
            $display("FAIL frz_ctl[%0d] frz=%b pc=%b fl=%b bub=%b exp=1/0/0/0",
                     i, pipe_freeze_o, pc_write_o, if_id_flush_o, id_ex_bubble_o);
         end
         tick();
         checks++;
         if (forward_a_o !== 2'b10 || stall_cnt_o !== 2 || flush_cnt_o !== 1) begin
            failures++;
            $display("FAIL frz_hold[%0d] fa=%b stall=%0d flush=%0d exp=10/2/1",
                     i, forward_a_o, stall_cnt_o, flush_cnt_o);
         end
      end
      mem_busy_i = 0;
      #1;
      checks++;
      if (pipe_freeze_o !== 0 || id_ex_bubble_o !== 1 || if_id_flush_o !== 0) begin
         failures++;
         $display("FAIL frz_release frz=%b bub=%b fl=%b exp=0/1/0",
                  pipe_freeze_o, id_ex_bubble_o, if_id_flush_o);
      end
      tick();
      checks++;
      if (forward_a_o !== 2'b00 || stall_cnt_o !== 3 || flush_cnt_o !== 1) begin
         failures++;
         $display("FAIL frz_after fa=%b stall=%0d flush=%0d exp=00/3/1",
                  forward_a_o, stall_cnt_o, flush_cnt_o);
      end
   endtask

   task automatic test_reset_in_freeze();
      clear_inputs();
      ex_regwrite_i = 1; ex_rd_i = 7; id_rs_i = 7;
      tick();
      mem_busy_i = 1; branch_taken_i = 1;
      tick();
      rst_i = 1;
      tick();
      checks++;
      if (forward_a_o !== 2'b00 || stall_cnt_o !== 0 || flush_cnt_o !== 0) begin
         failures++;
         $display("FAIL rst_frz fa=%b stall=%0d flush=%0d exp=00/0/0",
                  forward_a_o, stall_cnt_o, flush_cnt_o);
      end
      checks++;
      if (pipe_freeze_o !== 1) begin
         failures++;
         $display("FAIL rst_frz_comb frz=%b exp=1", pipe_freeze_o);
      end
      rst_i = 0;
      clear_inputs();
      branch_taken_i = 1;
      #1;
      checks++;
      if (pipe_freeze_o !== 0 || if_id_flush_o !== 1) begin
         failures++;
         $display("FAIL rst_run frz=%b fl=%b exp=0/1", pipe_freeze_o, if_id_flush_o);
      end
      tick();
      checks++;
      if (flush_cnt_o !== 1) begin
         failures++;
         $display("FAIL rst_run_cnt flush=%0d exp=1", flush_cnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_forward_priority();
      test_load_use();
      test_branch();
      test_freeze();
      test_reset_in_freeze();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
